// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array with leak, saturation, adaptive thresholds and refractory hold; optional LIF_SPIKE_COUNT_EN spike counter.
// Latency: tick -> N_NEURONS busy cycles -> one-cycle spike_valid; tick is ignored unless idle.
module lif_array #(
    parameter int N_NEURONS   = 4,
    parameter int W           = 8,
    parameter int DECAY_SHIFT = 3,
    parameter int THR_BASE    = 100,
    parameter int THR_INC     = 16,
    parameter int THR_MAX     = 240,
    parameter int REFRAC      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   learn_en,
    input  logic [N_NEURONS*W-1:0] currents,
    output logic                   busy,
    output logic                   spike_valid,
    output logic [N_NEURONS-1:0]   spikes,
    output logic [N_NEURONS*W-1:0] potentials,
    output logic [15:0]            spike_count
);

    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [N_NEURONS*W-1:0] r_cur;
    logic [W-1:0]           r_pot [N_NEURONS];
    logic [W-1:0]           r_thr [N_NEURONS];
    logic [RW-1:0]          r_ref [N_NEURONS];
    logic [N_NEURONS-1:0]   r_acc;
    logic [N_NEURONS-1:0]   r_spikes;
    logic                   r_busy;
    logic                   r_valid;

    logic [W-1:0]         w_pot, w_thr, w_cur, w_v, w_pot_nxt, w_thr_up, w_thr_dn, w_thr_nxt;
    logic [W:0]           w_sum, w_thr_inc;
    logic [RW-1:0]        w_ref, w_ref_nxt;
    logic                 w_refr, w_fire, w_last;
    logic [N_NEURONS-1:0] w_acc_nxt;

    always_comb begin
        w_pot     = r_pot[r_idx];
        w_thr     = r_thr[r_idx];
        w_ref     = r_ref[r_idx];
        w_cur     = r_cur[r_idx*W +: W];
        w_refr    = (w_ref != '0);
        // Leak never exceeds the potential, so the W+1-bit sum only overflows upward.
        w_sum     = {1'b0, w_pot} - {1'b0, (w_pot >> DECAY_SHIFT)} + {1'b0, w_cur};
        w_v       = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
        w_fire    = !w_refr && (w_v >= w_thr);
        w_pot_nxt = (w_refr || w_fire) ? '0 : w_v;
        w_ref_nxt = w_refr ? (w_ref - 1'b1) : (w_fire ? RW'(REFRAC) : '0);
        w_thr_inc = {1'b0, w_thr} + (W+1)'(THR_INC);
        w_thr_up  = (w_thr_inc > (W+1)'(THR_MAX)) ? W'(THR_MAX) : w_thr_inc[W-1:0];
        w_thr_dn  = (w_thr > W'(THR_BASE)) ? (w_thr - 1'b1) : w_thr;
        w_thr_nxt = !learn_en ? w_thr : (w_fire ? w_thr_up : w_thr_dn);
        w_last    = (r_idx == IW'(N_NEURONS - 1));
        w_acc_nxt = r_acc;
        w_acc_nxt[r_idx] = w_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cur    <= '0;
            r_acc    <= '0;
            r_spikes <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_pot[i] <= '0;
                r_thr[i] <= W'(THR_BASE);
                r_ref[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (tick) begin
                        r_cur   <= currents;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_pot[r_idx] <= w_pot_nxt;
                    r_thr[r_idx] <= w_thr_nxt;
                    r_ref[r_idx] <= w_ref_nxt;
                    r_acc        <= w_acc_nxt;
                    if (w_last) begin
                        r_spikes <= w_acc_nxt;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign spike_valid = r_valid;
    assign spikes      = r_spikes;

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_pot
        assign potentials[g*W +: W] = r_pot[g];
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] r_spike_count;
    logic [15:0] w_pop;
    logic [16:0] w_cnt_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_pop = w_pop + 16'(r_spikes[i]);
        end
        w_cnt_sum = {1'b0, r_spike_count} + {1'b0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spike_count <= '0;
        end else if (r_state == S_DONE) begin
            r_spike_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign spike_count = r_spike_count;
`else
    assign spike_count = '0;
`endif

endmodule
